// File: rtl/rs_pkg.sv
// Shared definitions for the ALU reservation station: op encodings, default
// widths and the entry record layout.
package rs_pkg;

    localparam int XLEN_D     = 32;
    localparam int RS_DEPTH_D = 16;
    localparam int TAG_W_D    = 4;
    localparam int OP_W_D     = 4;
    localparam int NUM_CDB_D  = 2;

    typedef enum logic [OP_W_D-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_EQ   = 4'd10,
        OP_NE   = 4'd11,
        OP_GE   = 4'd12,
        OP_GEU  = 4'd13
    } alu_op_e;

    // Entry layout at the default widths; rs_station re-declares it from its
    // own parameters so overridden widths stay consistent.
    typedef struct packed {
        logic                busy;
        logic [OP_W_D-1:0]   op;
        logic [XLEN_D-1:0]   vj;
        logic [XLEN_D-1:0]   vk;
        logic [TAG_W_D-1:0]  qj;
        logic [TAG_W_D-1:0]  qk;
        logic                qj_busy;
        logic                qk_busy;
        logic                use_imm;
        logic [XLEN_D-1:0]   imm;
        logic [TAG_W_D-1:0]  rob_tag;
    } rs_entry_t;

endpackage

// File: rtl/rs_station_if.sv
// Issue, common-data-bus and ALU dispatch signals of the reservation station.
// The master side drives issue/CDB and consumes dispatch; the slave is the station.
interface rs_station_if
    import rs_pkg::*;
#(
    parameter int XLEN    = XLEN_D,
    parameter int TAG_W   = TAG_W_D,
    parameter int OP_W    = OP_W_D,
    parameter int NUM_CDB = NUM_CDB_D
);
    logic                     issue_valid;
    logic                     issue_ready;
    logic [OP_W-1:0]          issue_op;
    logic [XLEN-1:0]          issue_vj;
    logic                     issue_qj_busy;
    logic [TAG_W-1:0]         issue_qj;
    logic [XLEN-1:0]          issue_vk;
    logic                     issue_qk_busy;
    logic [TAG_W-1:0]         issue_qk;
    logic [XLEN-1:0]          issue_imm;
    logic                     issue_use_imm;
    logic [TAG_W-1:0]         issue_rob_tag;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_value;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [OP_W-1:0]          alu_op;
    logic [XLEN-1:0]          alu_lhs;
    logic [XLEN-1:0]          alu_rhs;
    logic [TAG_W-1:0]         alu_rob_tag;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_qj_busy, issue_qj,
               issue_vk, issue_qk_busy, issue_qk, issue_imm, issue_use_imm,
               issue_rob_tag,
        input  issue_ready,
        output cdb_valid, cdb_tag, cdb_value,
        input  alu_valid, alu_op, alu_lhs, alu_rhs, alu_rob_tag,
        output alu_ready
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_qj_busy, issue_qj,
               issue_vk, issue_qk_busy, issue_qk, issue_imm, issue_use_imm,
               issue_rob_tag,
        output issue_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        output alu_valid, alu_op, alu_lhs, alu_rhs, alu_rob_tag,
        input  alu_ready
    );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder; found is low when no request bit is set.
module rs_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int IDX_W = $clog2(N);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// Reservation station for one ALU: holds renamed instructions, snoops the CDBs
// for pending operands and dispatches the lowest ready entry into a registered output.
module rs_station
    import rs_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int RS_DEPTH = RS_DEPTH_D,
    parameter int TAG_W    = TAG_W_D,
    parameter int OP_W     = OP_W_D,
    parameter int NUM_CDB  = NUM_CDB_D
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    rs_station_if.slave               bus,
    output logic [$clog2(RS_DEPTH):0] count
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [XLEN-1:0]   vj;
        logic [XLEN-1:0]   vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic              qj_busy;
        logic              qk_busy;
        logic              use_imm;
        logic [XLEN-1:0]   imm;
        logic [TAG_W-1:0]  rob_tag;
    } entry_t;

    entry_t              ent_q [RS_DEPTH];
    entry_t              ent_d [RS_DEPTH];
    entry_t              new_ent;
    logic [RS_DEPTH-1:0] busy_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                free_found;
    logic                sel_found;
    logic                issue_fire;
    logic                can_load;
    logic                dispatch;
    logic [CNT_W-1:0]    count_q;
    logic [XLEN:0]       snp_j [RS_DEPTH];
    logic [XLEN:0]       snp_k [RS_DEPTH];
    logic [XLEN:0]       snp_ij;
    logic [XLEN:0]       snp_ik;

    logic                alu_valid_q;
    logic [OP_W-1:0]     alu_op_q;
    logic [XLEN-1:0]     alu_lhs_q;
    logic [XLEN-1:0]     alu_rhs_q;
    logic [TAG_W-1:0]    alu_rob_tag_q;

    // Returns {hit, value}; iterating downward lets the lowest channel win.
    function automatic logic [XLEN:0] snoop(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  vals
    );
        logic [XLEN:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (vld[c] && tags[c*TAG_W +: TAG_W] == tag) begin
                res = {1'b1, vals[c*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
        end
    end

    rs_prio_enc #(.N(RS_DEPTH)) u_free_enc (
        .req   (~busy_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_enc #(.N(RS_DEPTH)) u_ready_enc (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign bus.issue_ready = rdy && !rst && free_found;
    assign issue_fire      = bus.issue_valid && bus.issue_ready;
    assign can_load        = !alu_valid_q || bus.alu_ready;
    assign dispatch        = can_load && sel_found;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            snp_j[i] = snoop(ent_q[i].qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            snp_k[i] = snoop(ent_q[i].qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        end
        snp_ij = snoop(bus.issue_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        snp_ik = snoop(bus.issue_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end

    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.op      = bus.issue_op;
        new_ent.vj      = bus.issue_vj;
        new_ent.vk      = bus.issue_vk;
        new_ent.qj      = bus.issue_qj;
        new_ent.qk      = bus.issue_qk;
        new_ent.qj_busy = bus.issue_qj_busy;
        new_ent.qk_busy = bus.issue_qk_busy && !bus.issue_use_imm;
        new_ent.use_imm = bus.issue_use_imm;
        new_ent.imm     = bus.issue_imm;
        new_ent.rob_tag = bus.issue_rob_tag;
        if (new_ent.qj_busy && snp_ij[XLEN]) begin
            new_ent.qj_busy = 1'b0;
            new_ent.vj      = snp_ij[XLEN-1:0];
        end
        if (new_ent.qk_busy && snp_ik[XLEN]) begin
            new_ent.qk_busy = 1'b0;
            new_ent.vk      = snp_ik[XLEN-1:0];
        end

        ent_d = ent_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].busy && ent_q[i].qj_busy && snp_j[i][XLEN]) begin
                ent_d[i].qj_busy = 1'b0;
                ent_d[i].vj      = snp_j[i][XLEN-1:0];
            end
            if (ent_q[i].busy && ent_q[i].qk_busy && snp_k[i][XLEN]) begin
                ent_d[i].qk_busy = 1'b0;
                ent_d[i].vk      = snp_k[i][XLEN-1:0];
            end
        end
        // Free slot comes from the pre-dispatch busy vector, so a slot vacated
        // this cycle is never the issue target.
        if (dispatch) begin
            ent_d[sel_idx].busy = 1'b0;
        end
        if (issue_fire) begin
            ent_d[free_idx] = new_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alu_valid_q   <= 1'b0;
            alu_op_q      <= '0;
            alu_lhs_q     <= '0;
            alu_rhs_q     <= '0;
            alu_rob_tag_q <= '0;
            count_q       <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    ent_q[i].busy <= 1'b0;
                end
                alu_valid_q <= 1'b0;
                count_q     <= '0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    ent_q[i] <= ent_d[i];
                end
                if (can_load) begin
                    alu_valid_q <= sel_found;
                    if (sel_found) begin
                        alu_op_q      <= ent_q[sel_idx].op;
                        alu_lhs_q     <= ent_q[sel_idx].vj;
                        alu_rhs_q     <= ent_q[sel_idx].use_imm ? ent_q[sel_idx].imm
                                                                : ent_q[sel_idx].vk;
                        alu_rob_tag_q <= ent_q[sel_idx].rob_tag;
                    end
                end
                count_q <= count_q + CNT_W'(issue_fire) - CNT_W'(dispatch);
            end
        end
    end

    assign bus.alu_valid   = alu_valid_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_lhs     = alu_lhs_q;
    assign bus.alu_rhs     = alu_rhs_q;
    assign bus.alu_rob_tag = alu_rob_tag_q;
    assign count           = count_q;

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: vector table of single ready issues plus hand-written
// sequences for wakeup, bypass, full, stall, rdy freeze, flush and reset.
module tb_rs_station;
    import rs_pkg::*;

    logic       clk;
    logic       rst;
    logic       rdy;
    logic       flush;
    logic [4:0] count;

    rs_station_if #(.XLEN(32), .TAG_W(4), .OP_W(4), .NUM_CDB(2)) bus ();

    rs_station #(
        .XLEN(32), .RS_DEPTH(16), .TAG_W(4), .OP_W(4), .NUM_CDB(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic        use_imm;
        logic [3:0]  rob;
        logic [31:0] exp_lhs;
        logic [31:0] exp_rhs;
    } vec_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    vec_t  vecs [6];
    int    errors = 0;
    int    checks = 0;
    int    n_disp = 0;
    logic        prev_hold = 1'b0;
    logic [71:0] hold_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and output-stability monitor, away from the active edge.
    always @(negedge clk) begin
        if (!rst && rdy && prev_hold) begin
            chk("hold_stable", {bus.alu_op, bus.alu_lhs, bus.alu_rhs, bus.alu_rob_tag}, hold_val);
        end
        if (!rst && rdy && !flush && bus.alu_valid && bus.alu_ready) begin
            n_disp++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch: got rob_tag=%0d, want no dispatch", bus.alu_rob_tag);
            end else begin
                mon_e = sb_q.pop_front();
                chk("dispatch", {bus.alu_op, bus.alu_lhs, bus.alu_rhs, bus.alu_rob_tag},
                    {mon_e.op, mon_e.lhs, mon_e.rhs, mon_e.tag});
            end
        end
        prev_hold = !rst && rdy && !flush && bus.alu_valid && !bus.alu_ready;
        hold_val  = {bus.alu_op, bus.alu_lhs, bus.alu_rhs, bus.alu_rob_tag};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] lhs,
                        input logic [31:0] rhs, input logic [3:0] tag);
        exp_t e;
        e.op = op; e.lhs = lhs; e.rhs = rhs; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic drive_issue(input logic [3:0] op, input logic [31:0] vj, input logic qjb,
                               input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                               input logic [3:0] qk, input logic [31:0] imm, input logic use_imm,
                               input logic [3:0] rob);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_vj      = vj;
        bus.issue_qj_busy = qjb;
        bus.issue_qj      = qj;
        bus.issue_vk      = vk;
        bus.issue_qk_busy = qkb;
        bus.issue_qk      = qk;
        bus.issue_imm     = imm;
        bus.issue_use_imm = use_imm;
        bus.issue_rob_tag = rob;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic qjb,
                         input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                         input logic [3:0] qk, input logic [31:0] imm, input logic use_imm,
                         input logic [3:0] rob);
        drive_issue(op, vj, qjb, qj, vk, qkb, qk, imm, use_imm, rob);
        step();
        bus.issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [1:0] vld, input logic [3:0] t1, input logic [31:0] v1,
                       input logic [3:0] t0, input logic [31:0] v0);
        bus.cdb_valid = vld;
        bus.cdb_tag   = {t1, t0};
        bus.cdb_value = {v1, v0};
    endtask

    task automatic wait_disp(input int target, input int budget, input string name);
        int n = 0;
        while (n_disp < target && n < budget) begin
            step();
            n++;
        end
        chk(name, (n_disp >= target) ? 1 : 0, 1);
    endtask

    int d0;

    initial begin
        vecs[0] = '{OP_ADD, 32'd5,          32'd7,          32'd0,          1'b0, 4'd3,  32'd5,          32'd7};
        vecs[1] = '{OP_SUB, 32'hFFFF_FFFF,  32'd1,          32'h20,         1'b1, 4'd7,  32'hFFFF_FFFF,  32'h20};
        vecs[2] = '{OP_XOR, 32'hA5A5_0000,  32'h0000_5A5A,  32'h1234,       1'b0, 4'd15, 32'hA5A5_0000,  32'h0000_5A5A};
        vecs[3] = '{OP_SLL, 32'd1,          32'hDEAD_BEEF,  32'd31,         1'b1, 4'd0,  32'd1,          32'd31};
        vecs[4] = '{OP_GEU, 32'h8000_0000,  32'h7FFF_FFFF,  32'd0,          1'b0, 4'd9,  32'h8000_0000,  32'h7FFF_FFFF};
        vecs[5] = '{OP_SRA, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b1, 4'd12, 32'd0,          32'hFFFF_FFFF};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        bus.issue_valid = 1'b0;
        drive_issue(4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        bus.issue_valid = 1'b0;
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        bus.alu_ready = 1'b1;

        // Reset
        step(); step();
        chk("rst_issue_ready", bus.issue_ready, 0);
        chk("rst_alu_valid", bus.alu_valid, 0);
        chk("rst_alu_fields", {bus.alu_op, bus.alu_lhs, bus.alu_rhs, bus.alu_rob_tag}, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        step();
        chk("post_rst_issue_ready", bus.issue_ready, 1);

        // Vector table: ready operands, two-cycle issue-to-dispatch latency
        foreach (vecs[i]) begin
            push(vecs[i].op, vecs[i].exp_lhs, vecs[i].exp_rhs, vecs[i].rob);
            d0 = n_disp;
            issue(vecs[i].op, vecs[i].vj, 1'b0, 4'd0, vecs[i].vk, 1'b0, 4'd0,
                  vecs[i].imm, vecs[i].use_imm, vecs[i].rob);
            chk("vec_n1_valid", bus.alu_valid, 0);
            chk("vec_n1_count", count, 1);
            step();
            chk("vec_n2_valid", bus.alu_valid, 1);
            chk("vec_n2_count", count, 0);
            step();
            chk("vec_dispatched", n_disp, d0 + 1);
        end

        // CDB wakeup on channel 1, three cycles after issue
        d0 = n_disp;
        push(OP_AND, 32'h100, 32'd2, 4'd1);
        issue(OP_AND, 32'hBAD, 1'b1, 4'd9, 32'd2, 1'b0, 4'd0, 32'd0, 1'b0, 4'd1);
        step();
        chk("wake_wait1", bus.alu_valid, 0);
        step();
        chk("wake_wait2", bus.alu_valid, 0);
        cdb(2'b11, 4'd9, 32'h100, 4'd8, 32'h999);
        step();
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        chk("wake_not_same_cycle", bus.alu_valid, 0);
        step();
        chk("wake_next_valid", bus.alu_valid, 1);
        chk("wake_lhs", bus.alu_lhs, 32'h100);
        wait_disp(d0 + 1, 4, "wake_dispatch");
        step();

        // Issue bypass, both channels match, channel 0 wins
        d0 = n_disp;
        push(OP_OR, 32'h11, 32'hAB, 4'd2);
        cdb(2'b11, 4'd4, 32'hCD, 4'd4, 32'hAB);
        issue(OP_OR, 32'h11, 1'b0, 4'd0, 32'hDEAD, 1'b1, 4'd4, 32'd0, 1'b0, 4'd2);
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        chk("byp_n1_valid", bus.alu_valid, 0);
        step();
        chk("byp_n2_valid", bus.alu_valid, 1);
        chk("byp_rhs", bus.alu_rhs, 32'hAB);
        wait_disp(d0 + 1, 4, "byp_dispatch");
        step();

        // use_imm ignores a pending source 2
        d0 = n_disp;
        push(OP_SLT, 32'd3, 32'h44, 4'd4);
        issue(OP_SLT, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h44, 1'b1, 4'd4);
        wait_disp(d0 + 1, 6, "imm_ignores_qk");
        step();

        // Fill all 16 entries with pending source 1
        d0 = n_disp;
        for (int i = 0; i < 16; i++) begin
            issue(OP_ADD, 32'd0, 1'b1, 4'(i), 32'(i * 16), 1'b0, 4'd0, 32'd0, 1'b0, 4'(i));
        end
        chk("full_count", count, 16);
        chk("full_issue_ready", bus.issue_ready, 0);
        chk("full_no_dispatch", bus.alu_valid, 0);
        issue(OP_SUB, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd14);
        chk("full_17th_rejected", count, 16);
        push(OP_ADD, 32'h55, 32'h50, 4'd5);
        cdb(2'b01, 4'd0, 32'd0, 4'd5, 32'h55);
        step();
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        chk("full_still_full", bus.issue_ready, 0);
        step();
        chk("full_e5_valid", bus.alu_valid, 1);
        chk("full_e5_tag", bus.alu_rob_tag, 5);
        chk("full_e5_count", count, 15);
        chk("full_e5_issue_ready", bus.issue_ready, 1);
        for (int t = 0; t < 16; t++) begin
            if (t != 5) begin
                push(OP_ADD, 32'h1000 + 32'(t), 32'(t * 16), 4'(t));
                cdb(2'b10, 4'(t), 32'h1000 + 32'(t), 4'd0, 32'd0);
                step();
            end
        end
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        wait_disp(d0 + 16, 40, "full_drain");
        chk("full_drain_count", count, 0);
        step();

        // ALU back-pressure with two ready entries
        d0 = n_disp;
        bus.alu_ready = 1'b0;
        push(OP_SUB, 32'h10, 32'h3, 4'd10);
        push(OP_XOR, 32'h20, 32'h4, 4'd11);
        issue(OP_SUB, 32'h10, 1'b0, 4'd0, 32'h3, 1'b0, 4'd0, 32'd0, 1'b0, 4'd10);
        issue(OP_XOR, 32'h20, 1'b0, 4'd0, 32'h4, 1'b0, 4'd0, 32'd0, 1'b0, 4'd11);
        chk("stall_valid", bus.alu_valid, 1);
        chk("stall_count", count, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_hold_tag", bus.alu_rob_tag, 10);
            chk("stall_hold_lhs", bus.alu_lhs, 32'h10);
        end
        bus.alu_ready = 1'b1;
        step();
        chk("b2b_second_valid", bus.alu_valid, 1);
        chk("b2b_second_tag", bus.alu_rob_tag, 11);
        chk("b2b_count", count, 0);
        step();
        chk("b2b_idle", bus.alu_valid, 0);
        chk("b2b_dispatches", n_disp, d0 + 2);

        // rdy low freezes the station and ignores issue
        d0 = n_disp;
        push(OP_EQ, 32'h9, 32'h9, 4'd6);
        issue(OP_EQ, 32'h9, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd6);
        rdy = 1'b0;
        drive_issue(OP_NE, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd0, 1'b0, 4'd7);
        step(); step(); step();
        chk("frz_valid", bus.alu_valid, 0);
        chk("frz_count", count, 1);
        chk("frz_issue_ready", bus.issue_ready, 0);
        bus.issue_valid = 1'b0;
        rdy = 1'b1;
        step();
        chk("frz_release_tag", {bus.alu_valid, bus.alu_rob_tag}, {1'b1, 4'd6});
        chk("frz_release_count", count, 0);
        step();
        chk("frz_dispatches", n_disp, d0 + 1);

        // Flush: ignored while rdy low, then empties station and output
        d0 = n_disp;
        bus.alu_ready = 1'b0;
        issue(OP_ADD, 32'h77, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        for (int i = 1; i < 6; i++) begin
            issue(OP_ADD, 32'd0, 1'b1, 4'(i), 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'(i));
        end
        chk("fl_pre_valid", bus.alu_valid, 1);
        chk("fl_pre_count", count, 5);
        rdy = 1'b0;
        flush = 1'b1;
        step();
        chk("fl_rdy_low_count", count, 5);
        chk("fl_rdy_low_valid", bus.alu_valid, 1);
        rdy = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_valid", bus.alu_valid, 0);
        bus.alu_ready = 1'b1;
        for (int t = 1; t < 6; t++) begin
            cdb(2'b01, 4'd0, 32'd0, 4'(t), 32'hF0 + 32'(t));
            step();
        end
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        step(); step(); step();
        chk("fl_no_stale_dispatch", n_disp, d0);
        chk("fl_no_stale_valid", bus.alu_valid, 0);

        // Reset while rdy is low still clears everything
        d0 = n_disp;
        bus.alu_ready = 1'b0;
        issue(OP_OR, 32'h33, 1'b0, 4'd0, 32'h44, 1'b0, 4'd0, 32'd0, 1'b0, 4'd13);
        issue(OP_OR, 32'd0, 1'b1, 4'd2, 32'h44, 1'b0, 4'd0, 32'd0, 1'b0, 4'd14);
        chk("mr_pre_valid", bus.alu_valid, 1);
        rdy = 1'b0;
        rst = 1'b1;
        step();
        chk("mr_fields", {bus.alu_valid, bus.alu_op, bus.alu_lhs, bus.alu_rhs, bus.alu_rob_tag}, 0);
        chk("mr_count", count, 0);
        rst = 1'b0;
        rdy = 1'b1;
        bus.alu_ready = 1'b1;
        cdb(2'b01, 4'd0, 32'd0, 4'd2, 32'h222);
        step();
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        step(); step();
        chk("mr_no_dispatch", n_disp, d0);

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised reservation station for the out-of-order core.
- Sits between the decoder/issue stage and one ALU.
- Holds issued ALU instructions with renamed source operands and captures operand values from NUM_CDB common-data-bus channels.
- Dispatches one ready entry per cycle to the ALU over a valid/ready handshake, tagged with its ROB index so the ALU result can be broadcast.

Parameters:
- XLEN, 32, data width of operands and immediates.
- RS_DEPTH, 16, number of entries; power of two, at least 2.
- TAG_W, 4, ROB tag width.
- OP_W, 4, ALU operation code width; codes come from the shared package.
- NUM_CDB, 2, number of broadcast channels snooped each cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state frozen when low
- flush  in  1  mispredict flush; empties the station
- issue_valid  in  1  issue request
- issue_ready  out  1  rdy && !full
- issue_op  in  OP_W  ALU operation
- issue_vj  in  XLEN  source-1 value, meaningful when issue_qj_busy=0
- issue_qj_busy  in  1  source-1 still pending
- issue_qj  in  TAG_W  ROB tag producing source 1
- issue_vk  in  XLEN  source-2 value
- issue_qk_busy  in  1  source-2 still pending
- issue_qk  in  TAG_W  ROB tag producing source 2
- issue_imm  in  XLEN  immediate
- issue_use_imm  in  1  rhs = imm; source 2 is ignored and treated as ready
- issue_rob_tag  in  TAG_W  destination ROB tag
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  packed tags; channel i uses bits [i*TAG_W +: TAG_W]
- cdb_value  in  NUM_CDB*XLEN  packed values
- alu_valid  out  1  dispatch valid (registered)
- alu_ready  in  1  ALU accepts this cycle
- alu_op  out  OP_W  operation
- alu_lhs  out  XLEN  Vj
- alu_rhs  out  XLEN  Vk or imm
- alu_rob_tag  out  TAG_W  destination tag
- count  out  $clog2(RS_DEPTH)+1  occupied entries, including none held in the output register

Behaviour:
- Reset:
  - all entries busy=0.
  - alu_valid=0; alu_op, alu_lhs, alu_rhs, alu_rob_tag = 0.
  - count=0; issue_ready=0 while rst is high.
- rdy low: no state changes, ignore issue and CDB, outputs hold. Producers re-broadcast after a stall.
- Issue (issue_valid && issue_ready):
  - write into the lowest-index free entry.
  - full = all entries busy; issue_ready=0 when full.
- Issue bypass: if an issue operand's pending tag matches any valid CDB channel in the same cycle, the entry stores the value with busy=0.
- Wakeup: for every busy entry, each pending operand whose tag matches cdb_tag[i] with cdb_valid[i] captures cdb_value[i]. If multiple channels match, the lowest channel wins.
- Ready: an entry is ready when busy and both operands are not pending. Readiness evaluates registered state, so an operand woken in cycle N makes the entry eligible in cycle N+1.
- Dispatch: the output register may load when !alu_valid || alu_ready.
  - When it may load, the lowest-index ready entry moves into it. The entry is freed the same edge (visible to issue next cycle), and alu_valid is set.
  - If no entry is ready, alu_valid is cleared.
  - While alu_valid && !alu_ready, all alu_* outputs are stable.
- Latency: issue with ready operands in cycle N -> alu_valid in cycle N+2, given an empty station and alu_ready=1.
- Simultaneous issue and dispatch: both allowed. A slot freed by dispatch is not reused in the same cycle.
- count tracks +issue -dispatch, both in the same edge.
- Flush:
  - clears every entry and alu_valid.
  - flush has priority over issue, wakeup and dispatch.
  - flush during rdy low is ignored.
- rst mid-operation: same as reset, regardless of rdy.

Decomposition:
- Package rs_pkg holds:
  - ALU op encodings: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, EQ, NE, GE, GEU.
  - default widths.
  - an entry record: busy, op, vj, vk, qj, qk, qj_busy, qk_busy, use_imm, imm, rob_tag.
- Sub-module: rs_prio_enc, a parametrised lowest-index priority encoder with a found flag. It is instantiated twice, for free-slot selection and for ready selection.

Test Plan:
- Issue ADD vj=5 vk=7, no pending, rob_tag=3, alu_ready=1 -> two cycles later alu_valid=1, lhs=5, rhs=7, rob_tag=3; count returns to 0.
- Issue qj_busy tag=9; CDB ch1 broadcasts tag 9 value 0x100 three cycles later -> dispatch the cycle after the wakeup with lhs=0x100.
- Issue with qk tag=4 in the same cycle CDB ch0 broadcasts tag 4 value 0xAB -> entry ready immediately; rhs=0xAB; no hang.
- Fill 16 entries with pending operands -> issue_ready=0 and count=16; a 17th issue_valid is not accepted. Wake entry 5 -> it dispatches first, then issue_ready=1.
- alu_ready=0 for 4 cycles with two ready entries -> outputs stable, entry 0 held; after release entry 0 then entry 1 dispatch back-to-back.
- Flush with 6 entries and alu_valid=1 -> next cycle count=0, alu_valid=0; a later CDB broadcast of an old tag causes no dispatch.
